// File: rtl/uart_pkg.sv
// Shared types and helpers for the two-requester UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  localparam int LEN_W = 2;

  // Picks byte 'idx' (0 = bits [7:0]) out of a 32-bit word.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [LEN_W-1:0] idx);
    logic [31:0] s;
    s = w >> {idx, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
// Combinational, zero latency; a grant is only ever given to a valid requester.
module uart_rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic rr_last,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = v0 && (!v1 || rr_last);
  assign gnt1 = v1 && (!v0 || !rr_last);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between two word requesters; bytes of a word go out one per start pulse.
// First start one cycle after accept; a requester is stalled (ready low) until the whole word is sent.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  output logic [7:0]       tx_sdata,
  output logic             tx_start,
  input  logic             tx_busy,
  output logic             busy,
  output logic             grant_id,
  output logic [31:0]      byte_count
);

  state_t           state;
  logic             rr_last;
  logic [31:0]      word_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] rem_nx;
  logic             gnt0;
  logic             gnt1;
  logic [31:0]      sel_data;
  logic [LEN_W-1:0] sel_len;

  uart_rr_arb2 u_arb (
    .v0      (req0_valid),
    .v1      (req1_valid),
    .rr_last (rr_last),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign req0_ready = (state == S_IDLE) && gnt0;
  assign req1_ready = (state == S_IDLE) && gnt1;
  assign sel_data   = gnt1 ? req1_data : req0_data;
  assign sel_len    = gnt1 ? req1_len : req0_len;
  assign rem_nx     = rem_q - LEN_W'(1);
  assign busy       = (state != S_IDLE);

  // tx_start is purely registered: uart_tx returns it on tx_busy combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      rr_last    <= 1'b1;
      word_q     <= '0;
      rem_q      <= '0;
      tx_sdata   <= '0;
      tx_start   <= 1'b0;
      grant_id   <= 1'b0;
      byte_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0_ready || req1_ready) begin
            word_q   <= sel_data;
            rem_q    <= sel_len;
            grant_id <= gnt1;
            rr_last  <= gnt1;
            tx_sdata <= BIG_ENDIAN ? sel_byte(sel_data, sel_len) : sel_data[7:0];
            tx_start <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          tx_start   <= 1'b0;
          byte_count <= byte_count + 32'd1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (!tx_busy) begin
            if (rem_q == '0) begin
              state <= S_IDLE;
            end else begin
              rem_q <= rem_nx;
              // Big-endian walks the byte index down; little-endian shifts the word.
              if (BIG_ENDIAN) begin
                tx_sdata <= sel_byte(word_q, rem_nx);
              end else begin
                word_q   <= word_q >> 8;
                tx_sdata <= word_q[15:8];
              end
              tx_start <= 1'b1;
              state    <= S_START;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: little- and big-endian arbiters share stimulus, each with its own uart_tx busy model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic [1:0]  req0_len = '0, req1_len = '0;
  logic        req0_ready_le, req1_ready_le, req0_ready_be, req1_ready_be;
  logic [7:0]  tx_sdata_le, tx_sdata_be;
  logic        tx_start_le, tx_start_be, tx_busy_le, tx_busy_be;
  logic        busy_le, busy_be, grant_id_le, grant_id_be;
  logic [31:0] byte_count_le, byte_count_be;

  int checks = 0;
  int failures = 0;
  int busy_len = 20;
  int cnt_le = 0, cnt_be = 0;
  int cyc = 0, fall_cyc = 0;
  int wide = 0, overlap = 0, hs0 = 0, hs1 = 0;
  logic prev_start = 1'b0, prev_busy = 1'b0;
  logic [7:0] q_dat[$];
  logic [7:0] q_be[$];
  logic       q_gid[$];
  int         q_gap[$];
  int         q_cyc[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_len(req0_len), .req0_ready(req0_ready_le),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_len(req1_len), .req1_ready(req1_ready_le),
    .tx_sdata(tx_sdata_le), .tx_start(tx_start_le), .tx_busy(tx_busy_le),
    .busy(busy_le), .grant_id(grant_id_le), .byte_count(byte_count_le)
  );

  uart_tx_arbiter #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_len(req0_len), .req0_ready(req0_ready_be),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_len(req1_len), .req1_ready(req1_ready_be),
    .tx_sdata(tx_sdata_be), .tx_start(tx_start_be), .tx_busy(tx_busy_be),
    .busy(busy_be), .grant_id(grant_id_be), .byte_count(byte_count_be)
  );

  // uart_tx stand-in: busy follows start combinationally, then stays high busy_len cycles.
  assign tx_busy_le = tx_start_le || (cnt_le != 0);
  assign tx_busy_be = tx_start_be || (cnt_be != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start_le) cnt_le <= busy_len;
    else if (cnt_le != 0) cnt_le <= cnt_le - 1;
    if (tx_start_be) cnt_be <= busy_len;
    else if (cnt_be != 0) cnt_be <= cnt_be - 1;
  end

  always @(negedge clk) begin
    if (tx_start_le && !prev_start) begin
      q_dat.push_back(tx_sdata_le);
      q_gid.push_back(grant_id_le);
      q_gap.push_back(cyc - fall_cyc);
      q_cyc.push_back(cyc);
      if (cnt_le != 0) overlap++;
    end
    if (tx_start_le && prev_start) wide++;
    if (tx_start_be) q_be.push_back(tx_sdata_be);
    if (req0_valid && req0_ready_le) hs0++;
    if (req1_valid && req1_ready_le) hs1++;
    if (!tx_busy_le && prev_busy) fall_cyc = cyc;
    prev_start = tx_start_le;
    prev_busy  = tx_busy_le;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_starts(input int base, input int n, input string tag);
    int t = 0;
    while (q_dat.size() < base + n && t < 2000) begin
      tick();
      t++;
    end
    chk(tag, q_dat.size() - base, n);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy_le || tx_busy_le || tx_busy_be) && t < 2000) begin
      tick();
      t++;
    end
    chk(tag, 32'(busy_le), 32'd0);
  endtask

  task automatic do_reset();
    wait_idle("pre_reset_idle");
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Offers one word, withdraws it as soon as the arbiter goes busy, then scrambles the inputs.
  task automatic send(input bit id, input logic [31:0] d, input logic [1:0] l);
    int n = 0;
    if (!id) begin
      req0_valid = 1'b1; req0_data = d; req0_len = l;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_len = l;
    end
    do begin
      tick();
      n++;
    end while (!busy_le && n < 50);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = ~d; req1_data = ~d; req0_len = ~l; req1_len = ~l;
  endtask

  initial begin
    int base, base_be, h0, ov, w, n, t;

    // Reset state, with both requesters already asserting a tie.
    req0_valid = 1'b1; req0_data = 32'h11; req0_len = 2'd0;
    req1_valid = 1'b1; req1_data = 32'h22; req1_len = 2'd0;
    #12;
    chk("rst_tx_start", 32'(tx_start_le), 32'd0);
    chk("rst_tx_sdata", 32'(tx_sdata_le), 32'd0);
    chk("rst_busy", 32'(busy_le), 32'd0);
    chk("rst_grant_id", 32'(grant_id_le), 32'd0);
    chk("rst_byte_count", byte_count_le, 32'd0);
    chk("rst_ready0_tie", 32'(req0_ready_le), 32'd1);
    chk("rst_ready1_tie", 32'(req1_ready_le), 32'd0);

    // Tie held from reset: grants alternate starting with req0.
    base = q_dat.size();
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_starts(base, 4, "tie_starts");
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("tie_idle");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_dat%0d", i), 32'(q_dat[base+i]), (i % 2 == 0) ? 32'h11 : 32'h22);
      chk($sformatf("tie_gid%0d", i), 32'(q_gid[base+i]), (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    // Single 4-byte word, little-endian order on dut_le, reversed on dut_be.
    do_reset();
    busy_len = 20;
    base = q_dat.size(); base_be = q_be.size(); h0 = hs0; w = wide;
    send(1'b0, 32'h44434241, 2'd3);
    wait_starts(base, 4, "single_starts");
    wait_idle("single_idle");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("single_le%0d", i), 32'(q_dat[base+i]), 32'h41 + 32'(i));
      chk($sformatf("single_be%0d", i), 32'(q_be[base_be+i]), 32'h44 - 32'(i));
    end
    for (int i = 1; i < 4; i++)
      chk($sformatf("single_gap%0d", i), 32'(q_gap[base+i]), 32'd1);
    chk("single_ready_cycles", 32'(hs0 - h0), 32'd1);
    chk("single_byte_count", byte_count_le, 32'd4);
    chk("single_one_cycle_start", 32'(wide - w), 32'd0);

    // req1, 2 bytes: big-endian sends CC then DD.
    base = q_dat.size(); base_be = q_be.size();
    send(1'b1, 32'hAABBCCDD, 2'd1);
    wait_starts(base, 2, "be_starts");
    chk("be_busy_mid", 32'(busy_be), 32'd1);
    chk("be_gid_mid", 32'(grant_id_be), 32'd1);
    wait_idle("be_idle");
    chk("be_dat0", 32'(q_be[base_be]), 32'hCC);
    chk("be_dat1", 32'(q_be[base_be+1]), 32'hDD);
    chk("be_le_dat0", 32'(q_dat[base]), 32'hDD);
    chk("be_le_dat1", 32'(q_dat[base+1]), 32'hCC);
    chk("be_gid0", 32'(q_gid[base]), 32'd1);
    chk("be_gid1", 32'(q_gid[base+1]), 32'd1);

    // Stretched busy: next start exactly one cycle after busy is seen low.
    busy_len = 50;
    base = q_dat.size(); ov = overlap; w = wide;
    send(1'b0, 32'h00000201, 2'd1);
    wait_starts(base, 2, "stretch_starts");
    wait_idle("stretch_idle");
    chk("stretch_dat0", 32'(q_dat[base]), 32'h01);
    chk("stretch_dat1", 32'(q_dat[base+1]), 32'h02);
    chk("stretch_no_overlap", 32'(overlap - ov), 32'd0);
    chk("stretch_gap", 32'(q_gap[base+1]), 32'd1);
    chk("stretch_spacing", 32'(q_cyc[base+1] - q_cyc[base]), 32'd52);
    chk("stretch_one_cycle_start", 32'(wide - w), 32'd0);
    chk("stretch_byte_count", byte_count_le, 32'd8);

    // Reset asserted while the third byte's start pulse is high.
    busy_len = 20;
    send(1'b0, 32'h04030201, 2'd3);
    n = 1; t = 0;
    while (n < 3 && t < 500) begin
      tick();
      t++;
      if (tx_start_le) n++;
    end
    chk("mid_start_high", 32'(tx_start_le), 32'd1);
    chk("mid_third_byte", 32'(tx_sdata_le), 32'h03);
    chk("mid_byte_count", byte_count_le, 32'd10);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_tx_start", 32'(tx_start_le), 32'd0);
    chk("mid_rst_busy", 32'(busy_le), 32'd0);
    chk("mid_rst_byte_count", byte_count_le, 32'd0);
    chk("mid_rst_tx_sdata", 32'(tx_sdata_le), 32'd0);
    for (int i = 0; i < 25; i++) tick();
    rstn = 1'b1;
    tick();
    base = q_dat.size();
    send(1'b0, 32'h0000AA55, 2'd1);
    wait_starts(base, 2, "post_rst_starts");
    wait_idle("post_rst_idle");
    chk("post_rst_dat0", 32'(q_dat[base]), 32'h55);
    chk("post_rst_dat1", 32'(q_dat[base+1]), 32'hAA);
    chk("post_rst_byte_count", byte_count_le, 32'd2);

    // byte_count wraps from all-ones to zero.
    force dut_le.byte_count = 32'hFFFFFFFF;
    #1;
    release dut_le.byte_count;
    #1;
    chk("wrap_preset", byte_count_le, 32'hFFFFFFFF);
    base = q_dat.size();
    send(1'b0, 32'h0000005A, 2'd0);
    wait_starts(base, 1, "wrap_starts");
    wait_idle("wrap_idle");
    chk("wrap_dat", 32'(q_dat[base]), 32'h5A);
    chk("wrap_byte_count", byte_count_le, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
